pe_mac_drain: RTL and testbench

- Parametrised next-generation systolic-array processing element.
- Per-operand valid/last passthrough and signed/unsigned MAC with selectable saturation.
- Multi-entry drain buffer with valid/ready back-pressure.
- Sticky error reporting for dropped results and misaligned operands; tiled in a 2D grid exactly like the current PE.

---
 rtl/pe_mac_drain_if.sv | 56 +++++
 rtl/pe_mac_drain.sv | 140 ++++++++++++++
 tb/tb_pe_mac_drain.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pe_mac_drain_if.sv
// Operand, result and control bundle of one systolic processing element.
//   a_* / b_*      : operand inputs and their registered passthrough copies
//   drain_*        : result FIFO head with valid/ready back-pressure
//   mode/sat/clr   : arithmetic mode, saturation enable, sticky-error clear
//   busy_o, err_o  : tile-in-progress flag and sticky error bits
// master = upstream/neighbour driving the PE, slave = the PE itself.
interface pe_mac_drain_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32
);
  logic              mode_signed_i;
  logic              sat_en_i;
  logic              a_valid_i;
  logic [DATA_W-1:0] a_data_i;
  logic              a_last_i;
  logic              b_valid_i;
  logic [DATA_W-1:0] b_data_i;
  logic              b_last_i;
  logic              a_valid_o;
  logic [DATA_W-1:0] a_data_o;
  logic              a_last_o;
  logic              b_valid_o;
  logic [DATA_W-1:0] b_data_o;
  logic              b_last_o;
  logic              drain_valid_o;
  logic [ACC_W-1:0]  drain_data_o;
  logic              drain_ovf_o;
  logic              drain_ready_i;
  logic              busy_o;
  logic [1:0]        err_o;
  logic              clr_err_i;

  modport master (
    output mode_signed_i, sat_en_i,
    output a_valid_i, a_data_i, a_last_i,
    output b_valid_i, b_data_i, b_last_i,
    input  a_valid_o, a_data_o, a_last_o,
    input  b_valid_o, b_data_o, b_last_o,
    input  drain_valid_o, drain_data_o, drain_ovf_o,
    output drain_ready_i,
    input  busy_o, err_o,
    output clr_err_i
  );

  modport slave (
    input  mode_signed_i, sat_en_i,
    input  a_valid_i, a_data_i, a_last_i,
    input  b_valid_i, b_data_i, b_last_i,
    output a_valid_o, a_data_o, a_last_o,
    output b_valid_o, b_data_o, b_last_o,
    output drain_valid_o, drain_data_o, drain_ovf_o,
    input  drain_ready_i,
    output busy_o, err_o,
    input  clr_err_i
  );
endinterface

// File: rtl/pe_mac_drain.sv
// Systolic-array processing element: registered A/B passthrough, signed or
// unsigned multiply-accumulate over a tile with optional saturation, and a
// circular drain FIFO of {ovf, result} with valid/ready back-pressure.
// Ports: clk_i, rst_ni (async active-low), bus (pe_mac_drain_if.slave).
// The interface must be instantiated with the same DATA_W/ACC_W.
module pe_mac_drain #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned DRAIN_DEPTH = 2
) (
  input logic           clk_i,
  input logic           rst_ni,
  pe_mac_drain_if.slave bus
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned PTR_W  = (DRAIN_DEPTH > 1) ? $clog2(DRAIN_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DRAIN_DEPTH + 1);
  localparam int unsigned ENT_W  = ACC_W + 1;

  // passthrough registers
  logic              a_valid_q, a_last_q, b_valid_q, b_last_q;
  logic [DATA_W-1:0] a_data_q, b_data_q;

  // tile state
  logic [ACC_W-1:0]  acc_q;
  logic              tovf_q, first_q, busy_q;
  logic [1:0]        err_q;

  // drain FIFO
  logic [ENT_W-1:0]  mem_q [DRAIN_DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              beat, close, mis, pop, push, drop, full;
  logic [PROD_W-1:0] prod_u;
  logic signed [PROD_W-1:0] prod_s;
  logic [ACC_W-1:0]  prod_x, base, res;
  logic [ACC_W:0]    sum;
  logic              ovf, tile_ovf;
  logic [ENT_W-1:0]  head;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DRAIN_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake decode
  always_comb begin
    beat  = bus.a_valid_i & bus.b_valid_i;
    close = beat & bus.a_last_i & bus.b_last_i;
    mis   = (bus.a_valid_i ^ bus.b_valid_i) | (beat & (bus.a_last_i ^ bus.b_last_i));
    full  = (cnt_q == CNT_W'(DRAIN_DEPTH));
    pop   = (cnt_q != '0) & bus.drain_ready_i;
    push  = close & (~full | pop);
    drop  = close & full & ~pop;
  end

  // MAC datapath: one guard bit above ACC_W exposes carry / sign overflow
  always_comb begin
    prod_u = PROD_W'(bus.a_data_i) * PROD_W'(bus.b_data_i);
    prod_s = PROD_W'($signed(bus.a_data_i)) * PROD_W'($signed(bus.b_data_i));
    if (bus.mode_signed_i) prod_x = ACC_W'(prod_s);
    else                   prod_x = ACC_W'(prod_u);
    base = first_q ? '0 : acc_q;
    if (bus.mode_signed_i) begin
      sum = {base[ACC_W-1], base} + {prod_x[ACC_W-1], prod_x};
      ovf = sum[ACC_W] ^ sum[ACC_W-1];
    end else begin
      sum = {1'b0, base} + {1'b0, prod_x};
      ovf = sum[ACC_W];
    end
    res = sum[ACC_W-1:0];
    if (ovf && bus.sat_en_i) begin
      if (!bus.mode_signed_i) res = '1;
      // sum[ACC_W] is the true sign of the unclamped signed result
      else if (sum[ACC_W])    res = {1'b1, {(ACC_W-1){1'b0}}};
      else                    res = {1'b0, {(ACC_W-1){1'b1}}};
    end
    tile_ovf = ovf | (~first_q & tovf_q);
  end

  // Control and tile state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
      a_last_q  <= 1'b0;
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_last_q  <= 1'b0;
      acc_q     <= '0;
      tovf_q    <= 1'b0;
      first_q   <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      a_valid_q <= bus.a_valid_i;
      a_data_q  <= bus.a_data_i;
      a_last_q  <= bus.a_last_i;
      b_valid_q <= bus.b_valid_i;
      b_data_q  <= bus.b_data_i;
      b_last_q  <= bus.b_last_i;
      if (beat) begin
        acc_q   <= res;
        tovf_q  <= tile_ovf;
        first_q <= close;
        busy_q  <= ~close;
      end
      // a set event wins over a same-cycle clear
      err_q[0] <= (err_q[0] & ~bus.clr_err_i) | drop;
      err_q[1] <= (err_q[1] & ~bus.clr_err_i) | mis;
      if (push) wr_q <= ptr_next(wr_q);
      if (pop)  rd_q <= ptr_next(rd_q);
      if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // FIFO storage needs no reset: entries are only visible while counted
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= {tile_ovf, res};
  end

  assign head              = mem_q[rd_q];
  assign bus.a_valid_o     = a_valid_q;
  assign bus.a_data_o      = a_data_q;
  assign bus.a_last_o      = a_last_q;
  assign bus.b_valid_o     = b_valid_q;
  assign bus.b_data_o      = b_data_q;
  assign bus.b_last_o      = b_last_q;
  assign bus.drain_valid_o = (cnt_q != '0);
  assign bus.drain_data_o  = (cnt_q != '0) ? head[ACC_W-1:0] : '0;
  assign bus.drain_ovf_o   = (cnt_q != '0) ? head[ACC_W] : 1'b0;
  assign bus.busy_o        = busy_q;
  assign bus.err_o         = err_q;

endmodule

// File: tb/tb_pe_mac_drain.sv
// Bench for pe_mac_drain: directed tiles with literal expectations, then a
// randomized run compared every cycle against an arithmetic/queue model.
module tb_pe_mac_drain;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ACC_W       = 16;
  localparam int unsigned DRAIN_DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_mac_drain_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  pe_mac_drain #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DRAIN_DEPTH(DRAIN_DEPTH)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic             e_av = 0, e_al = 0, e_bv = 0, e_bl = 0;
  logic [DATA_W-1:0] e_ad = 0, e_bd = 0;
  logic [ACC_W-1:0] m_acc = 0;
  bit               m_first = 1, m_busy = 0, m_tovf = 0;
  logic [1:0]       m_err = 0;
  logic [ACC_W:0]   q[$];

  always @(posedge clk or negedge rst_n) begin : model
    longint base, p, s, mx, mn;
    bit ov, set0, set1, do_pop;
    logic [ACC_W-1:0] r;
    if (!rst_n) begin
      e_av = 0; e_ad = 0; e_al = 0; e_bv = 0; e_bd = 0; e_bl = 0;
      m_acc = 0; m_first = 1; m_busy = 0; m_tovf = 0; m_err = 0;
      q.delete();
    end else begin
      do_pop = (q.size() != 0) && bus.drain_ready_i;
      set1 = (bus.a_valid_i != bus.b_valid_i) ||
             (bus.a_valid_i && bus.b_valid_i && bus.a_last_i != bus.b_last_i);
      set0 = 0;
      if (do_pop) void'(q.pop_front());
      if (bus.a_valid_i && bus.b_valid_i) begin
        if (bus.mode_signed_i) begin
          base = m_first ? 0 : longint'($signed(m_acc));
          p  = longint'($signed(bus.a_data_i)) * longint'($signed(bus.b_data_i));
          s  = base + p;
          mx = (longint'(1) <<< (ACC_W - 1)) - 1;
          mn = -(longint'(1) <<< (ACC_W - 1));
          ov = (s > mx) || (s < mn);
          if (ov && bus.sat_en_i) s = (s > mx) ? mx : mn;
        end else begin
          base = m_first ? 0 : longint'(m_acc);
          p  = longint'(bus.a_data_i) * longint'(bus.b_data_i);
          s  = base + p;
          mx = (longint'(1) <<< ACC_W) - 1;
          ov = s > mx;
          if (ov && bus.sat_en_i) s = mx;
        end
        r = ACC_W'(s);
        m_tovf = (m_first ? 1'b0 : m_tovf) | ov;
        if (bus.a_last_i && bus.b_last_i) begin
          if (q.size() < DRAIN_DEPTH) q.push_back({m_tovf, r});
          else set0 = 1;
          m_first = 1;
          m_busy = 0;
        end else begin
          m_acc = r;
          m_first = 0;
          m_busy = 1;
        end
      end
      m_err[0] = (m_err[0] & ~bus.clr_err_i) | set0;
      m_err[1] = (m_err[1] & ~bus.clr_err_i) | set1;
      e_av = bus.a_valid_i; e_ad = bus.a_data_i; e_al = bus.a_last_i;
      e_bv = bus.b_valid_i; e_bd = bus.b_data_i; e_bl = bus.b_last_i;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    logic [ACC_W:0] hd;
    hd = (q.size() != 0) ? q[0] : '0;
    chk("a_valid_o", 64'(bus.a_valid_o), 64'(e_av));
    chk("a_data_o",  64'(bus.a_data_o),  64'(e_ad));
    chk("a_last_o",  64'(bus.a_last_o),  64'(e_al));
    chk("b_valid_o", 64'(bus.b_valid_o), 64'(e_bv));
    chk("b_data_o",  64'(bus.b_data_o),  64'(e_bd));
    chk("b_last_o",  64'(bus.b_last_o),  64'(e_bl));
    chk("drain_valid_o", 64'(bus.drain_valid_o), 64'(q.size() != 0));
    chk("drain_data_o",  64'(bus.drain_data_o),  64'(hd[ACC_W-1:0]));
    chk("drain_ovf_o",   64'(bus.drain_ovf_o),   64'(hd[ACC_W]));
    chk("busy_o", 64'(bus.busy_o), 64'(m_busy));
    chk("err_o",  64'(bus.err_o),  64'(m_err));
  end

  // ---------------- stimulus ----------------
  // One cycle of operands; valids drop again just after the sampling edge.
  task automatic drive(input logic av, input logic [7:0] a, input logic al,
                       input logic bv, input logic [7:0] b, input logic bl);
    @(negedge clk);
    bus.a_valid_i = av; bus.a_data_i = a; bus.a_last_i = al;
    bus.b_valid_i = bv; bus.b_data_i = b; bus.b_last_i = bl;
    @(posedge clk); #1;
    bus.a_valid_i = 1'b0;
    bus.b_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    bus.mode_signed_i = 0; bus.sat_en_i = 0;
    bus.a_valid_i = 0; bus.a_data_i = 0; bus.a_last_i = 0;
    bus.b_valid_i = 0; bus.b_data_i = 0; bus.b_last_i = 0;
    bus.drain_ready_i = 0; bus.clr_err_i = 0;
    repeat (2) @(negedge clk);
    chk("reset busy_o", 64'(bus.busy_o), 64'd0);
    chk("reset drain_valid_o", 64'(bus.drain_valid_o), 64'd0);
    rst_n = 1'b1;

    // unsigned 3*4 + 5*6
    drive(1, 8'd3, 0, 1, 8'd4, 0);
    chk("t1 busy mid-tile", 64'(bus.busy_o), 64'd1);
    chk("t1 a_data passthrough", 64'(bus.a_data_o), 64'd3);
    drive(1, 8'd5, 1, 1, 8'd6, 1);
    chk("t1 valid", 64'(bus.drain_valid_o), 64'd1);
    chk("t1 result", 64'(bus.drain_data_o), 64'd42);
    chk("t1 ovf", 64'(bus.drain_ovf_o), 64'd0);
    chk("t1 busy after close", 64'(bus.busy_o), 64'd0);
    bus.drain_ready_i = 1; idle(1); bus.drain_ready_i = 0;

    // signed (-2)*3 + 4*(-5) = -26
    bus.mode_signed_i = 1;
    drive(1, 8'hFE, 0, 1, 8'd3, 0);
    drive(1, 8'd4, 1, 1, 8'hFB, 1);
    chk("t2 result", 64'(bus.drain_data_o), 64'hFFE6);
    chk("t2 ovf", 64'(bus.drain_ovf_o), 64'd0);
    bus.drain_ready_i = 1; idle(1); bus.drain_ready_i = 0;

    // unsigned overflow, saturate then wrap
    bus.mode_signed_i = 0; bus.sat_en_i = 1;
    drive(1, 8'd255, 0, 1, 8'd255, 0);
    drive(1, 8'd255, 1, 1, 8'd255, 1);
    chk("t3 sat result", 64'(bus.drain_data_o), 64'hFFFF);
    chk("t3 sat ovf", 64'(bus.drain_ovf_o), 64'd1);
    bus.drain_ready_i = 1; idle(1); bus.drain_ready_i = 0;
    bus.sat_en_i = 0;
    drive(1, 8'd255, 0, 1, 8'd255, 0);
    drive(1, 8'd255, 1, 1, 8'd255, 1);
    chk("t3 wrap result", 64'(bus.drain_data_o), 64'hFC02);
    chk("t3 wrap ovf", 64'(bus.drain_ovf_o), 64'd1);
    bus.drain_ready_i = 1; idle(1); bus.drain_ready_i = 0;

    // overfill: third result dropped
    drive(1, 8'd1, 1, 1, 8'd1, 1);
    drive(1, 8'd1, 1, 1, 8'd2, 1);
    drive(1, 8'd1, 1, 1, 8'd3, 1);
    chk("t4 drop err", 64'(bus.err_o), 64'd1);
    chk("t4 head", 64'(bus.drain_data_o), 64'd1);
    bus.drain_ready_i = 1; idle(1);
    chk("t4 second", 64'(bus.drain_data_o), 64'd2);
    idle(1);
    chk("t4 empty", 64'(bus.drain_valid_o), 64'd0);
    bus.drain_ready_i = 0; bus.clr_err_i = 1; idle(1); bus.clr_err_i = 0;
    chk("t4 cleared", 64'(bus.err_o), 64'd0);

    // full buffer with simultaneous pop and push
    drive(1, 8'd1, 1, 1, 8'd5, 1);
    drive(1, 8'd1, 1, 1, 8'd6, 1);
    bus.drain_ready_i = 1;
    drive(1, 8'd1, 1, 1, 8'd7, 1);
    bus.drain_ready_i = 0;
    chk("t5 no drop", 64'(bus.err_o), 64'd0);
    chk("t5 head", 64'(bus.drain_data_o), 64'd6);
    bus.drain_ready_i = 1; idle(1);
    chk("t5 tail", 64'(bus.drain_data_o), 64'd7);
    idle(1);
    chk("t5 empty", 64'(bus.drain_valid_o), 64'd0);
    bus.drain_ready_i = 0;

    // misalignment, then async reset mid-tile
    drive(1, 8'd9, 0, 0, 8'd0, 0);
    chk("t6 misalign", 64'(bus.err_o), 64'd2);
    drive(1, 8'd2, 0, 1, 8'd3, 0);
    chk("t6 busy", 64'(bus.busy_o), 64'd1);
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("t6 rst busy", 64'(bus.busy_o), 64'd0);
    chk("t6 rst a_valid", 64'(bus.a_valid_o), 64'd0);
    chk("t6 rst a_data", 64'(bus.a_data_o), 64'd0);
    chk("t6 rst err", 64'(bus.err_o), 64'd0);
    #1 rst_n = 1'b1;
    drive(1, 8'd2, 1, 1, 8'd2, 1);
    chk("t6 fresh tile", 64'(bus.drain_data_o), 64'd4);
    chk("t6 fresh ovf", 64'(bus.drain_ovf_o), 64'd0);
    bus.drain_ready_i = 1; idle(1); bus.drain_ready_i = 0;

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic l;
      @(negedge clk);
      if (m_first && $urandom_range(0, 7) == 0) begin
        bus.mode_signed_i = 1'($urandom_range(0, 1));
        bus.sat_en_i      = 1'($urandom_range(0, 1));
      end
      r = int'($urandom_range(0, 15));
      bus.a_valid_i = (r < 13);
      bus.b_valid_i = (r < 12) || (r == 13);
      bus.a_data_i  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      bus.b_data_i  = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
      l = ($urandom_range(0, 3) == 0);
      bus.a_last_i  = l;
      bus.b_last_i  = ($urandom_range(0, 31) == 0) ? ~l : l;
      bus.drain_ready_i = ($urandom_range(0, 3) != 0);
      bus.clr_err_i = ($urandom_range(0, 63) == 0);
    end
    @(negedge clk);
    bus.a_valid_i = 0; bus.b_valid_i = 0; bus.clr_err_i = 0;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
